// File: rtl/fifo_word_packer_pkg.sv
// +------------------------------------------------------------------+
// | fifo_word_packer_pkg : shared defaults and FSM state encoding    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package fifo_word_packer_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_PACK  = 4;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_word_packer_if.sv
// +------------------------------------------------------------------+
// | fifo_word_packer_if : upstream FIFO read + downstream word bus   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface fifo_word_packer_if
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PACK  = DEFAULT_PACK
);

  logic                    empty;
  logic [WIDTH-1:0]        readData;
  logic                    readEn;
  logic [WIDTH*PACK-1:0]   outData;
  logic                    outValid;
  logic                    outReady;
  logic [3:0]              nibCnt;
  logic [7:0]              wordsOut;

  modport master (
    output empty, readData, outReady,
    input  readEn, outData, outValid, nibCnt, wordsOut
  );

  modport slave (
    input  empty, readData, outReady,
    output readEn, outData, outValid, nibCnt, wordsOut
  );

endinterface

`default_nettype wire

// File: rtl/fifo_word_packer_pack_shifter.sv
// +------------------------------------------------------------------+
// | pack_shifter : slot-indexed nibble write into the assembly reg   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module pack_shifter
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PACK  = DEFAULT_PACK
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  wr_en,
  input  wire logic [WIDTH-1:0]      wr_data,
  input  wire logic                  clr,
  output logic      [WIDTH*PACK-1:0] asm_reg,
  output logic      [3:0]            asm_cnt
);

  logic [WIDTH*PACK-1:0] asm_reg_q, asm_reg_d;
  logic [3:0]            asm_cnt_q, asm_cnt_d;

  always_comb begin
    asm_reg_d = asm_reg_q;
    asm_cnt_d = asm_cnt_q;
    // clr only arrives in HOLD, where no read can be pending
    if (clr) begin
      asm_cnt_d = 4'd0;
    end else if (wr_en) begin
      for (int s = 0; s < PACK; s++) begin
        if (asm_cnt_q == 4'(s)) begin
          asm_reg_d[s*WIDTH +: WIDTH] = wr_data;
        end
      end
      asm_cnt_d = asm_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg_q <= '0;
      asm_cnt_q <= 4'd0;
    end else begin
      asm_reg_q <= asm_reg_d;
      asm_cnt_q <= asm_cnt_d;
    end
  end

  assign asm_reg = asm_reg_q;
  assign asm_cnt = asm_cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// +------------------------------------------------------------------+
// | fifo_word_packer : packs PACK FIFO nibbles into one output word  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PACK  = DEFAULT_PACK
) (
  input wire logic          clk,
  input wire logic          rst,
  fifo_word_packer_if.slave bus
);

  localparam logic [3:0] PACK_CNT = 4'(PACK);

  pack_state_e           state_q, state_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [WIDTH*PACK-1:0] out_reg_q, out_reg_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            words_out_q, words_out_d;

  logic [WIDTH*PACK-1:0] asm_reg;
  logic [3:0]            asm_cnt;
  logic [4:0]            fill_level;
  logic                  rd_en;
  logic                  copy;
  logic                  accept;

  // Count the read already in flight so the register never over-fills
  assign fill_level = {1'b0, asm_cnt} + 5'(rd_pend_q);
  assign rd_en      = !rst && !bus.empty && (fill_level < {1'b0, PACK_CNT});
  assign accept     = out_valid_q && bus.outReady;

  pack_shifter #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) u_pack_shifter (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_pend_q),
    .wr_data (bus.readData),
    .clr     (copy),
    .asm_reg (asm_reg),
    .asm_cnt (asm_cnt)
  );

  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (rd_pend_q && (asm_cnt == PACK_CNT - 4'd1)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!out_valid_q || bus.outReady) begin
          copy    = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    rd_pend_d   = rd_en;
    out_reg_d   = out_reg_q;
    out_valid_d = out_valid_q;
    words_out_d = words_out_q;
    if (copy) begin
      out_reg_d   = asm_reg;
      out_valid_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      words_out_d = words_out_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      rd_pend_q   <= 1'b0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
      words_out_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      words_out_q <= words_out_d;
    end
  end

  assign bus.readEn   = rd_en;
  assign bus.outData  = out_reg_q;
  assign bus.outValid = out_valid_q;
  assign bus.nibCnt   = asm_cnt;
  assign bus.wordsOut = words_out_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// +------------------------------------------------------------------+
// | tb_fifo_word_packer : scoreboard bench with upstream FIFO model  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fifo_word_packer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.WIDTH(4), .PACK(4)) bus ();

  fifo_word_packer #(.WIDTH(4), .PACK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  fifo_q[$];
  logic [15:0] exp_q[$];
  int          pop_cnt = 0;
  int          acc_cnt = 0;
  int          valid_cycles = 0;
  int          cyc = 0;
  int          last_acc = 0;
  bit          have_last = 0;
  bit          spacing_en = 0;

  // Upstream sync FIFO: readData appears one cycle after readEn is sampled
  initial begin
    logic pop;
    bus.empty    = 1'b1;
    bus.readData = 4'h0;
    forever begin
      @(negedge clk);
      #2;
      bus.empty = (fifo_q.size() == 0);
      #1;
      pop = bus.readEn;
      if (bus.empty) begin
        checks++;
        if (bus.readEn !== 1'b0) begin
          errors++;
          $display("FAIL readEn_while_empty actual=%b required=0 t=%0t", bus.readEn, $time);
        end
      end
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) begin
        bus.readData = fifo_q.pop_front();
        pop_cnt++;
      end
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (rst) begin
        acc_cnt   = 0;
        have_last = 0;
      end else begin
        if (bus.outValid) valid_cycles++;
        if (bus.outValid && bus.outReady) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", bus.outData);
          end else begin
            exp = exp_q.pop_front();
            if (bus.outData !== exp) begin
              errors++;
              $display("FAIL outData actual=%h required=%h", bus.outData, exp);
            end
          end
          checks++;
          if (bus.wordsOut !== 8'(acc_cnt)) begin
            errors++;
            $display("FAIL wordsOut_pre actual=%0d required=%0d", bus.wordsOut, acc_cnt);
          end
          acc_cnt++;
          if (spacing_en) begin
            if (have_last) begin
              checks++;
              if (cyc - last_acc != 6) begin
                errors++;
                $display("FAIL word_spacing actual=%0d required=6", cyc - last_acc);
              end
            end
            last_acc  = cyc;
            have_last = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
  endtask

  task automatic wait_words(input int n);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.wordsOut == 8'(n)) break;
    end
    checks++;
    if (k == 100) begin
      errors++;
      $display("FAIL wait_words_timeout actual=%0d required=%0d", bus.wordsOut, n);
    end
  endtask

  task automatic wait_nib(input int n, input bit need_valid);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.nibCnt == 4'(n) && (!need_valid || bus.outValid)) break;
    end
    checks++;
    if (k == 100) begin
      errors++;
      $display("FAIL wait_nib_timeout actual=%0d required=%0d", bus.nibCnt, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_readEn"},   32'(bus.readEn),   32'd0);
    check({tag, "_outValid"}, 32'(bus.outValid), 32'd0);
    check({tag, "_outData"},  32'(bus.outData),  32'd0);
    check({tag, "_nibCnt"},   32'(bus.nibCnt),   32'd0);
    check({tag, "_wordsOut"}, 32'(bus.wordsOut), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.outReady = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single word, downstream always ready
    @(negedge clk);
    bus.outReady = 1'b1;
    exp_q.push_back(16'h4321);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    wait_words(1);
    repeat (3) @(negedge clk);
    check("t1_readEn_pulses", 32'(pop_cnt), 32'd4);
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_outValid_low", 32'(bus.outValid), 32'd0);
    check("t1_wordsOut", 32'(bus.wordsOut), 32'd1);

    // Backpressure: first word held, second parks in HOLD
    bus.outReady = 1'b0;
    exp_q.push_back(16'h4321);
    exp_q.push_back(16'hF765);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    push(4'h5); push(4'h6); push(4'h7); push(4'hF);
    wait_nib(4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_outData", 32'(bus.outData), 32'h4321);
      check("t2_hold_readEn", 32'(bus.readEn), 32'd0);
      @(negedge clk);
    end
    bus.outReady = 1'b1;
    wait_words(3);
    repeat (2) @(negedge clk);
    check("t2_outValid_low", 32'(bus.outValid), 32'd0);

    // Empty gap mid-word
    push(4'h1); push(4'h2);
    repeat (10) @(negedge clk);
    check("t3_nibCnt", 32'(bus.nibCnt), 32'd2);
    check("t3_readEn", 32'(bus.readEn), 32'd0);
    check("t3_outValid", 32'(bus.outValid), 32'd0);
    exp_q.push_back(16'h4321);
    push(4'h3); push(4'h4);
    wait_words(4);

    // Reset mid-word
    push(4'h1); push(4'h2); push(4'h3);
    wait_nib(3, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(16'hDCBA);
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    wait_words(1);

    // Continuous stream of 16 nibbles
    @(negedge clk);
    spacing_en = 1;
    exp_q.push_back(16'h4321);
    exp_q.push_back(16'h8765);
    exp_q.push_back(16'hCBA9);
    exp_q.push_back(16'h0FED);
    for (int i = 1; i <= 16; i++) push(4'(i));
    wait_words(5);
    repeat (3) @(negedge clk);
    check("t5_wordsOut", 32'(bus.wordsOut), 32'd5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter WIDTH, default 4, FIFO entry (nibble) width in bits.
REQ-002 Parameter PACK, default 4, nibbles per output word; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 empty  input  1  upstream sync-FIFO empty flag.
REQ-006 readData  input  WIDTH  upstream FIFO read register; valid exactly one cycle after readEn is sampled high.
REQ-007 readEn  output  1  pop request to upstream FIFO.
REQ-008 outData  output  WIDTH*PACK  assembled word.
REQ-009 outValid  output  1  outData holds a word.
REQ-010 outReady  input  1  downstream accepts; transfer occurs on a clock edge where outValid and outReady are both high.
REQ-011 nibCnt  output  4  nibbles currently held in the assembly register (0..PACK).
REQ-012 wordsOut  output  8  count of completed output transfers; wraps 255->0.

Function
REQ-013 The block SHALL keep registers asmReg (WIDTH*PACK), asmCnt, rdPend (1 bit, registered copy of readEn), outReg and outValid.
REQ-014 readEn SHALL be combinational: high iff empty==0 and asmCnt+rdPend < PACK; it SHALL never be high while empty==1.
REQ-015 On every edge with rdPend==1, readData SHALL be written into nibble slot asmCnt of asmReg (slot 0 = bits WIDTH-1:0) and asmCnt SHALL increment; the first nibble popped lands in the LSBs.
REQ-016 FSM states: FILL (asmCnt<PACK) and HOLD (asmCnt==PACK).
REQ-017 FILL->HOLD on the edge that writes slot PACK-1.
REQ-018 In HOLD, if outValid==0 or outReady==1, the next edge SHALL copy asmReg to outReg, set outValid=1, clear asmCnt to 0 and return to FILL; otherwise it remains in HOLD and issues no reads.
REQ-019 outValid SHALL clear on an accepting edge unless a HOLD->FILL copy occurs on that same edge, in which case it stays high with the new word.
REQ-020 outData SHALL equal outReg and be stable while outValid==1 and outReady==0.
REQ-021 wordsOut SHALL increment on every edge where outValid && outReady.
REQ-022 With empty==0 continuously and outReady==1, the block SHALL deliver one word every PACK+2 cycles; no nibble SHALL be lost or duplicated under any empty or outReady pattern.
REQ-023 An empty gap mid-word SHALL pause assembly with asmCnt held; assembly resumes when empty returns low.

Reset
REQ-024 While rst is high: readEn=0, rdPend=0, asmCnt=0, asmReg=0, outReg=0, outValid=0, wordsOut=0, FSM=FILL.
REQ-025 Reset mid-word SHALL discard partial asmReg contents and any in-flight read; first read is possible on the first edge after rst deasserts.

Structure
REQ-026 WIDTH, PACK defaults and the FILL/HOLD state encoding SHALL live in the shared FIFO package used by the FIFO top.
REQ-027 One sub-module, pack_shifter (slot-indexed write into asmReg plus asmCnt), SHALL be used; FSM and output register stay in the top.

Verification
REQ-028 Write 1,2,3,4 to the FIFO, outReady=1 -> readEn pulses 4 times, outData=16'h4321, outValid high 1 cycle, wordsOut=1.
REQ-029 Write 8 nibbles 1..7,F with outReady=0 -> first word 16'h4321 held stable; second assembles to HOLD, readEn stays 0; raising outReady -> 16'h4321 then 16'hF765 on consecutive accepts, wordsOut=2.
REQ-030 Write 1,2 only; wait 10 cycles -> nibCnt=2, readEn=0, outValid=0; write 3,4 -> outData=16'h4321.
REQ-031 Assert rst after 3 nibbles captured -> all outputs 0 asynchronously; afterwards write A,B,C,D -> outData=16'hDCBA.
REQ-032 Continuous writes of 16 nibbles, outReady=1 -> 4 words at PACK+2=6-cycle spacing, readEn never high while empty=1, data matches FIFO order.
